// File: rtl/common_fw_arb_pkg.sv
// Shared types, sizes and helpers for the firmware device-pin arbiter.
package common_fw_arb_pkg;

  localparam int N_FW           = 4;
  localparam int IDX_W          = 2;
  localparam int GAP_CYCLES_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_RELEASE
  } arb_state_e;

  function automatic logic [N_FW-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_FW-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/common_fw_rr_pick.sv
// Round-robin pick: first set request after last_owner, wrapping; last_owner itself is tried last.
module common_fw_rr_pick
  import common_fw_arb_pkg::*;
(
  input  logic [N_FW-1:0]  req,
  input  logic [IDX_W-1:0] last_owner,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;

  // Walk from farthest to nearest so the nearest requester after last_owner wins.
  always_comb begin
    valid = 1'b0;
    idx   = last_owner;
    cand  = last_owner;
    for (int k = N_FW; k >= 1; k--) begin
      cand = last_owner + IDX_W'(k);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/common_fw_dev_arbiter.sv
// Grants the shared DUT pins to one firmware requester at a time, with a guard gap between owners.
module common_fw_dev_arbiter
  import common_fw_arb_pkg::*;
#(
  parameter int N_FW       = 4,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
  input  logic             fw_clk,
  input  logic             fw_rst,
  input  logic [N_FW-1:0]  fw_req,
  input  logic             sw_force_en,
  input  logic [IDX_W-1:0] sw_force_sel,
  output logic [N_FW-1:0]  fw_dev_id_enable,
  output logic [N_FW-1:0]  fw_grant,
  output logic             busy,
  output logic [15:0]      switch_cnt
);

  arb_state_e       state_q;
  logic [IDX_W-1:0] owner_q;
  logic [IDX_W-1:0] last_owner_q;
  logic             forced_q;
  logic [7:0]       gap_q;
  logic [15:0]      switch_cnt_q;
  logic [N_FW-1:0]  enable_q;
  logic             busy_q;

  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] owner_d;
  logic             release_d;

  common_fw_rr_pick u_pick (
    .req        (fw_req),
    .last_owner (last_owner_q),
    .valid      (pick_valid),
    .idx        (pick_idx)
  );

  // A forced grant ends on force drop or retarget; a normal grant ends when its owner lets go,
  // or when software forces a different target. Forcing the current owner keeps the grant.
  always_comb begin
    owner_d   = sw_force_en ? sw_force_sel : pick_idx;
    release_d = 1'b0;
    if (forced_q)
      release_d = !sw_force_en || (sw_force_sel != owner_q);
    else if (sw_force_en)
      release_d = (sw_force_sel != owner_q);
    else
      release_d = !fw_req[owner_q];
  end

  always_ff @(posedge fw_clk) begin
    if (fw_rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= IDX_W'(N_FW - 1);
      last_owner_q <= IDX_W'(N_FW - 1);
      forced_q     <= 1'b0;
      gap_q        <= '0;
      switch_cnt_q <= '0;
      enable_q     <= '0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sw_force_en || pick_valid) begin
            state_q      <= ST_GRANT;
            owner_q      <= owner_d;
            last_owner_q <= owner_d;
            forced_q     <= sw_force_en;
            enable_q     <= onehot(owner_d);
            busy_q       <= 1'b1;
            if (switch_cnt_q != 16'hFFFF)
              switch_cnt_q <= switch_cnt_q + 16'd1;
          end
        end
        ST_GRANT: begin
          if (release_d) begin
            state_q  <= ST_RELEASE;
            gap_q    <= '0;
            enable_q <= '0;
          end else if (sw_force_en) begin
            forced_q <= 1'b1;
          end
        end
        ST_RELEASE: begin
          if (gap_q == 8'(GAP_CYCLES - 1)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            gap_q <= gap_q + 8'd1;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          enable_q <= '0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign fw_dev_id_enable = enable_q;
  assign fw_grant         = enable_q;
  assign busy             = busy_q;
  assign switch_cnt       = switch_cnt_q;

endmodule
